// File: rtl/bin2bcd_seq_param.sv
// rtl/bin2bcd_seq_param.sv - sequential shift/add-3 binary-to-BCD converter, one bit per clock
// Optional sticky overflow detection is enabled by defining BCD_OVF_DETECT_EN.
module bin2bcd_seq_param #(
    parameter int W      = 8,
    parameter int D      = 3,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_init,
    input  logic [W-1:0]   in_bin,
    output logic [4*D-1:0] out_bcd,
    output logic           out_sign,
    output logic           out_busy,
    output logic           out_DONE,
    output logic           out_overflow
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t         r_state;
    logic [W-1:0]   r_mag;
    logic [4*D-1:0] r_work;
    logic [CW-1:0]  r_cnt;
    logic           r_sign_lat;
    logic [4*D-1:0] r_bcd;
    logic           r_sign;
    logic           r_busy;
    logic           r_done;

    logic           w_neg;
    logic [W-1:0]   w_mag_in;
    logic [4*D-1:0] w_adj;
    logic [4*D-1:0] w_next;
    logic           w_last;

    // Most negative input negates to itself, which reads correctly as unsigned 2^(W-1)
    assign w_neg    = (SIGNED != 0) && in_bin[W-1];
    assign w_mag_in = w_neg ? (~in_bin + W'(1)) : in_bin;
    assign w_last   = (r_cnt == CW'(1));

    always_comb begin
        w_adj = r_work;
        for (int k = 0; k < D; k++) begin
            if (r_work[4*k +: 4] >= 4'd5)
                w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
        end
    end

    assign w_next = {w_adj[4*D-2:0], r_mag[W-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_mag      <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_sign_lat <= 1'b0;
            r_bcd      <= '0;
            r_sign     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (in_init) begin
                        r_state    <= S_CONV;
                        r_mag      <= w_mag_in;
                        r_sign_lat <= w_neg;
                        r_work     <= '0;
                        r_cnt      <= CW'(W);
                        r_busy     <= 1'b1;
                    end
                end
                S_CONV: begin
                    r_work <= w_next;
                    r_mag  <= r_mag << 1;
                    r_cnt  <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_bcd   <= w_next;
                        r_sign  <= r_sign_lat;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BCD_OVF_DETECT_EN
    logic r_ovf_flag;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf_flag <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (r_state == S_IDLE && in_init) begin
            r_ovf_flag <= 1'b0;
        end else if (r_state == S_CONV) begin
            r_ovf_flag <= r_ovf_flag | w_adj[4*D-1];
            if (w_last)
                r_ovf <= r_ovf_flag | w_adj[4*D-1];
        end
    end

    assign out_overflow = r_ovf;
`else
    logic w_unused_top;
    assign w_unused_top = w_adj[4*D-1];
    assign out_overflow = 1'b0;
`endif

    assign out_bcd  = r_bcd;
    assign out_sign = r_sign;
    assign out_busy = r_busy;
    assign out_DONE = r_done;

endmodule

// File: tb/tb_bin2bcd_seq_param.sv
// tb/tb_bin2bcd_seq_param.sv - randomized and directed check of bin2bcd_seq_param against an arithmetic model
module tb_bin2bcd_seq_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  init = 4'b0;
    logic [15:0] bin = 16'd0;

    logic [11:0] bcd0, bcd1;
    logic [7:0]  bcd2;
    logic [19:0] bcd3;
    logic [3:0]  sign, busy, done, ovf;
    logic [19:0] bcd_a [4];
    logic [19:0] prev_b [4];
    logic [3:0]  prev_s, prev_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_param #(.W(8), .D(3), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .in_init(init[0]), .in_bin(bin[7:0]),
        .out_bcd(bcd0), .out_sign(sign[0]), .out_busy(busy[0]),
        .out_DONE(done[0]), .out_overflow(ovf[0]));
    bin2bcd_seq_param #(.W(8), .D(3), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .in_init(init[1]), .in_bin(bin[7:0]),
        .out_bcd(bcd1), .out_sign(sign[1]), .out_busy(busy[1]),
        .out_DONE(done[1]), .out_overflow(ovf[1]));
    bin2bcd_seq_param #(.W(8), .D(2), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .in_init(init[2]), .in_bin(bin[7:0]),
        .out_bcd(bcd2), .out_sign(sign[2]), .out_busy(busy[2]),
        .out_DONE(done[2]), .out_overflow(ovf[2]));
    bin2bcd_seq_param #(.W(16), .D(5), .SIGNED(0)) u3 (
        .clk(clk), .rst(rst), .in_init(init[3]), .in_bin(bin),
        .out_bcd(bcd3), .out_sign(sign[3]), .out_busy(busy[3]),
        .out_DONE(done[3]), .out_overflow(ovf[3]));

    always_comb begin
        bcd_a[0] = {8'd0, bcd0};
        bcd_a[1] = {8'd0, bcd1};
        bcd_a[2] = {12'd0, bcd2};
        bcd_a[3] = bcd3;
    end

    function automatic int wof(input int i);
        return (i == 3) ? 16 : 8;
    endfunction

    function automatic int dof(input int i);
        case (i)
            2:       return 2;
            3:       return 5;
            default: return 3;
        endcase
    endfunction

    // Decimal digits from integer division; overflow is a plain magnitude comparison
    function automatic void model(input int idx, input logic [15:0] v,
                                  output logic [19:0] eb, output logic es, output logic eo);
        longint raw, mag, m, pw;
        int w, d;
        bit neg;
        w   = wof(idx);
        d   = dof(idx);
        raw = longint'(v) & ((longint'(1) << w) - 1);
        neg = (idx == 1) && (((raw >> (w - 1)) & 1) != 0);
        mag = neg ? ((longint'(1) << w) - raw) : raw;
        pw  = 1;
        for (int k = 0; k < d; k++) pw = pw * 10;
        m  = mag % pw;
        eb = '0;
        for (int k = 0; k < d; k++) begin
            eb[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        es = neg;
`ifdef BCD_OVF_DETECT_EN
        eo = (mag >= pw);
`else
        eo = 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int idx, input logic [15:0] v, input string tag);
        logic [19:0] eb;
        logic es, eo;
        int n;
        bit seen;
        model(idx, v, eb, es, eo);
        @(negedge clk);
        bin = v;
        init[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init[idx] = 1'b0;
        chk({tag, "_hold"}, 32'(bcd_a[idx]), 32'(prev_b[idx]));
        n = 0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done[idx]) seen = 1;
            else begin
                if (busy[idx]) n++;
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(n), 32'(wof(idx)));
        chk({tag, "_busy_at_done"}, 32'(busy[idx]), 32'd0);
        chk({tag, "_bcd"}, 32'(bcd_a[idx]), 32'(eb));
        chk({tag, "_sign"}, 32'(sign[idx]), 32'(es));
        chk({tag, "_ovf"}, 32'(ovf[idx]), 32'(eo));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done[idx]), 32'd0);
        prev_b[idx] = eb;
        prev_s[idx] = es;
        prev_o[idx] = eo;
    endtask

    initial begin
        int acc, phase;
        bit nodone;
        for (int i = 0; i < 4; i++) prev_b[i] = '0;
        prev_s = '0;
        prev_o = '0;
        #12;
        chk("reset_bcd0", 32'(bcd0), 32'd0);
        chk("reset_flags", {16'd0, sign, busy, done, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run(0, 16'd255, "t1_255");
        run(0, 16'd0,   "t2_0");
        run(0, 16'd9,   "t2_9");
        run(1, 16'h80,  "t3_m128");
        run(1, 16'hF6,  "t3_m10");
        run(1, 16'd127, "t3_127");
        run(1, 16'hFF,  "t3_m1");
        run(2, 16'd100, "t4_100");
        run(2, 16'd99,  "t4_99");
        run(2, 16'd255, "t4_255");
        run(3, 16'd0,   "t5_0");

        // Held start: second accept lands exactly W+2 edges after the first
        @(negedge clk);
        bin = 16'hFFFF;
        init[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bin = 16'd5;
        acc = 0;
        phase = 0;
        for (int k = 1; k <= 40 && acc == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done[3]) chk("t5_65535_bcd", 32'(bcd3), 32'h65535);
            if (phase == 0 && !busy[3]) phase = 1;
            else if (phase == 1 && busy[3]) acc = k;
        end
        chk("t5_reaccept_edge", 32'(acc), 32'd18);
        init[3] = 1'b0;
        nodone = 0;
        for (int k = 0; k < 30 && !nodone; k++) begin
            @(negedge clk);
            if (done[3]) nodone = 1;
        end
        chk("t5_second_done", 32'(nodone), 32'd1);
        chk("t5_second_bcd", 32'(bcd3), 32'h00005);
        prev_b[3] = 20'h00005;

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) run(i, 16'($urandom), $sformatf("rnd%0d_%0d", i, r));
        end

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        bin = 16'd200;
        init[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_bcd0", 32'(bcd0), 32'd0);
        chk("t6_rst_flags", {16'd0, sign, busy, done, ovf}, 32'd0);
        chk("t6_rst_bcd3", 32'(bcd3), 32'd0);
        for (int i = 0; i < 4; i++) prev_b[i] = '0;
        nodone = 1;
        repeat (12) begin
            @(negedge clk);
            if (done != 4'd0 || busy != 4'd0) nodone = 0;
        end
        chk("t6_quiet_in_reset", 32'(nodone), 32'd1);
        rst = 1'b1;
        run(0, 16'd42, "t6_42");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
